// File: rtl/fifo_arb_pkg.sv
// Shared types for the dual-clock FIFO write-port arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE / GRANT)
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request bit strictly after ptr, wrapping around,
// so the bit at ptr itself has the lowest priority.
// Ports:
//   req  in  NUM_REQ  request vector
//   ptr  in  PW       last-served index
//   any  out 1        at least one request set
//   idx  out PW       chosen index (0 when none set)
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic               any,
    output logic [PW-1:0]      idx
);

    logic found;
    int   cand;

    assign any = |req;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_dc_write_arbiter.sv
// Shares the write-clock side of one dual-clock FIFO among NUM_REQ requesters.
// Round-robin grant per packet; the owner keeps the port until its req_last
// beat is accepted. A new packet is only granted when the FIFO reports at
// least MIN_FREE free words.
// Ports:
//   clock         in   FIFO write clock
//   reset_n       in   async active-low reset
//   req_valid     in   per-requester beat valid
//   req_last      in   per-requester final beat of packet
//   req_data      in   per-requester data, requester i at [i*WIDTH +: WIDTH]
//   req_ready     out  per-requester beat accepted when valid & ready
//   fifo_wrreq    out  FIFO write request
//   fifo_data     out  FIFO write data
//   fifo_wrfull   in   FIFO write-side full
//   fifo_wrusedw  in   FIFO write-side used words
//   grant_id      out  current / last owner index
//   busy          out  a packet currently owns the port
//
// state     | meaning
// ARB_IDLE  | no owner; arbitrate when a requester is valid and space is ok
// ARB_GRANT | grant_id owns the port until its last beat is written
module fifo_dc_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 32,
    parameter int WIDTHU   = 9,
    parameter int NUMWORDS = 512,
    parameter int MIN_FREE = 4,
    parameter int GW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     fifo_wrreq,
    output logic [WIDTH-1:0]         fifo_data,
    input  logic                     fifo_wrfull,
    input  logic [WIDTHU-1:0]        fifo_wrusedw,
    output logic [GW-1:0]            grant_id,
    output logic                     busy
);

    arb_state_t    state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] rr_q, rr_d;
    logic          busy_q, busy_d;

    logic          pick_any;
    logic [GW-1:0] pick_idx;
    logic [WIDTHU:0] free_words;
    logic          space_ok;
    logic          beat;

    // One extra bit so NUMWORDS itself is representable. wrusedw wraps to 0
    // on a full power-of-two FIFO, hence the wrfull qualifier.
    assign free_words = (WIDTHU+1)'(NUMWORDS) - {1'b0, fifo_wrusedw};
    assign space_ok   = !fifo_wrfull && (free_words >= (WIDTHU+1)'(MIN_FREE));

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (GW)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            rr_q    <= GW'(NUM_REQ - 1);
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        busy_d     = busy_q;
        req_ready  = '0;
        fifo_wrreq = 1'b0;
        fifo_data  = '0;
        beat       = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any && space_ok) begin
                    grant_d = pick_idx;
                    busy_d  = 1'b1;
                    state_d = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                // Only the owner is ever ready; wrfull stalls it mid-packet.
                req_ready[grant_q] = !fifo_wrfull;
                fifo_data          = req_data[int'(grant_q)*WIDTH +: WIDTH];
                beat               = req_valid[grant_q] && !fifo_wrfull;
                fifo_wrreq         = beat;
                if (beat && req_last[grant_q]) begin
                    rr_d    = grant_q;
                    busy_d  = 1'b0;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign grant_id = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fifo_dc_write_arbiter.sv
// Bench for fifo_dc_write_arbiter with a behavioural 16-word FIFO standing in
// for the write side of lpm_fifo_dc (zero-latency wrusedw / wrfull).
module tb_fifo_dc_write_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int WU   = 4;
    localparam int NW   = 16;
    localparam int MF   = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_wrreq;
    logic [W-1:0]      fifo_data;
    logic              fifo_wrfull;
    logic [WU-1:0]     fifo_wrusedw;
    logic [1:0]        grant_id;
    logic              busy;

    // FIFO model
    logic [W-1:0]  fmem [NW];
    logic [WU-1:0] wp  = '0;
    logic [WU-1:0] rp  = '0;
    logic [WU:0]   cnt = '0;
    logic          pop = 1'b0;
    logic          wr_ok;
    logic          rd_ok;

    // Requester beat queues
    logic [W-1:0] bmem  [NREQ][16];
    logic         blast [NREQ][16];
    logic [3:0]   head  [NREQ] = '{default: '0};
    logic [3:0]   tail  [NREQ] = '{default: '0};

    logic [W-1:0] exp_q [$];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    fifo_dc_write_arbiter #(
        .NUM_REQ  (NREQ),
        .WIDTH    (W),
        .WIDTHU   (WU),
        .NUMWORDS (NW),
        .MIN_FREE (MF)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wrreq   (fifo_wrreq),
        .fifo_data    (fifo_data),
        .fifo_wrfull  (fifo_wrfull),
        .fifo_wrusedw (fifo_wrusedw),
        .grant_id     (grant_id),
        .busy         (busy)
    );

    assign wr_ok        = fifo_wrreq && (cnt < 5'(NW));
    assign rd_ok        = pop && (cnt != 5'd0);
    assign fifo_wrfull  = (cnt == 5'(NW));
    assign fifo_wrusedw = cnt[WU-1:0];

    always @(posedge clock) begin
        if (wr_ok) begin
            fmem[wp] <= fifo_data;
            wp       <= wp + 4'd1;
        end
        if (rd_ok) rp <= rp + 4'd1;
        cnt <= cnt + {4'b0, wr_ok} - {4'b0, rd_ok};
    end

    always_comb begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = (head[i] != tail[i]);
            req_last[i]         = blast[i][head[i]];
            req_data[i*W +: W]  = bmem[i][head[i]];
        end
    end

    always @(posedge clock) begin
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && req_ready[i]) head[i] <= head[i] + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // A write while full would be an overflow / dropped beat.
    always @(negedge clock) begin
        if (fifo_wrfull) check("no_write_when_full", 32'(fifo_wrreq), 32'd0);
    end

    function automatic logic pending();
        logic p = 1'b0;
        for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) p = 1'b1;
        return p;
    endfunction

    task automatic send(input int r, input logic [W-1:0] d, input logic last, input logic expect_it);
        bmem[r][tail[r]]  = d;
        blast[r][tail[r]] = last;
        tail[r]           = tail[r] + 4'd1;
        if (expect_it) exp_q.push_back(d);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        while ((busy || pending()) && n < max_cyc) begin
            tick();
            n++;
        end
        check(tag, 32'(busy | pending()), 32'd0);
    endtask

    task automatic read_word(input string tag);
        int n = 0;
        logic [W-1:0] got;
        logic [W-1:0] want;
        while (cnt == 5'd0 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_avail"}, 32'(cnt != 5'd0), 32'd1);
        if (cnt != 5'd0) begin
            got  = fmem[rp];
            pop  = 1'b1;
            tick();
            pop  = 1'b0;
            want = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_DEAD;
            check(tag, got, want);
        end
    endtask

    initial begin
        int n;
        int exp_id;

        // 1: reset held with every requester valid
        tick();
        for (int i = 0; i < NREQ; i++) send(i, 32'hA0 + 32'(i), 1'b1, 1'b1);
        send(0, 32'hA0, 1'b1, 1'b1);
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_wrreq", 32'(fifo_wrreq), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_data",  fifo_data, 32'd0);
        tick();
        reset_n = 1'b1;

        // 2: round robin, single-beat packets, grants two cycles apart
        for (int k = 1; k <= 10; k++) begin
            @(posedge clock);
            #1;
            if (k % 2 == 1) begin
                exp_id = ((k - 1) / 2) % NREQ;
                check("rr_busy",  32'(busy), 32'd1);
                check("rr_grant", 32'(grant_id), 32'(exp_id));
                check("rr_wrreq", 32'(fifo_wrreq), 32'd1);
                check("rr_data",  fifo_data, 32'hA0 + 32'(exp_id));
            end else begin
                check("rr_idle_busy",  32'(busy), 32'd0);
                check("rr_idle_wrreq", 32'(fifo_wrreq), 32'd0);
            end
        end
        tick();
        repeat (5) read_word("rr_order");

        // 3: atomicity with bubbles while another requester waits
        send(0, 32'hC0, 1'b0, 1'b1);
        tick();
        check("atom_grant", 32'(grant_id), 32'd0);
        send(1, 32'hB1, 1'b1, 1'b0);
        tick();
        repeat (2) begin
            check("atom_bubble_busy",  32'(busy), 32'd1);
            check("atom_bubble_ready", 32'(req_ready), 32'd1);
            check("atom_bubble_wrreq", 32'(fifo_wrreq), 32'd0);
            tick();
        end
        send(0, 32'hC1, 1'b0, 1'b1);
        send(0, 32'hC2, 1'b1, 1'b1);
        exp_q.push_back(32'hB1);
        wait_idle("atom_idle", 30);
        repeat (4) read_word("atom_order");

        // 4: MIN_FREE headroom at packet start
        for (int j = 0; j < 13; j++) send(3, 32'hD0 + 32'(j), (j == 12), 1'b1);
        wait_idle("hdr_fill_idle", 40);
        check("hdr_used", 32'(fifo_wrusedw), 32'd13);
        send(2, 32'hE2, 1'b1, 1'b0);
        repeat (5) begin
            tick();
            check("hdr_no_grant", 32'(busy), 32'd0);
        end
        read_word("hdr_first");
        exp_q.push_back(32'hE2);
        n = 0;
        while (!busy && n < 4) begin
            tick();
            n++;
        end
        check("hdr_grant_seen", 32'(busy), 32'd1);
        check("hdr_grant_id",   32'(grant_id), 32'd2);
        check("hdr_latency",    32'(n <= 2), 32'd1);
        wait_idle("hdr_idle", 20);
        repeat (13) read_word("hdr_order");

        // 5: full stall mid-packet
        for (int j = 0; j < 12; j++) send(1, 32'h100 + 32'(j), (j == 11), 1'b1);
        wait_idle("stall_prefill_idle", 40);
        for (int j = 0; j < 6; j++) send(0, 32'hF0 + 32'(j), (j == 5), 1'b1);
        n = 0;
        while (!fifo_wrfull && n < 12) begin
            tick();
            n++;
        end
        check("stall_full", 32'(fifo_wrfull), 32'd1);
        send(1, 32'h1B1, 1'b1, 1'b1);
        repeat (3) begin
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_wrreq", 32'(fifo_wrreq), 32'd0);
            check("stall_owner", 32'(grant_id), 32'd0);
            check("stall_busy",  32'(busy), 32'd1);
            tick();
        end
        read_word("stall_drain");
        check("stall_resume_wrreq", 32'(fifo_wrreq), 32'd1);
        check("stall_resume_data",  fifo_data, 32'hF4);
        tick();
        check("stall_refull", 32'(fifo_wrfull), 32'd1);
        read_word("stall_drain");
        check("stall_last_data", fifo_data, 32'hF5);
        tick();
        check("stall_done_busy", 32'(busy), 32'd0);
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            read_word("stall_order");
            n++;
        end
        wait_idle("stall_idle", 20);

        // 6: reset in the middle of a packet
        for (int j = 0; j < 4; j++) send(0, 32'h200 + 32'(j), (j == 3), 1'b1);
        tick();
        tick();
        send(2, 32'h2E2, 1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mrst_ready", 32'(req_ready), 32'd0);
        check("mrst_wrreq", 32'(fifo_wrreq), 32'd0);
        check("mrst_busy",  32'(busy), 32'd0);
        check("mrst_grant", 32'(grant_id), 32'd0);
        check("mrst_data",  fifo_data, 32'd0);
        tick();
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("mrst_regrant_busy", 32'(busy), 32'd1);
        check("mrst_regrant_id",   32'(grant_id), 32'd0);
        check("mrst_regrant_data", fifo_data, 32'h201);
        exp_q.push_back(32'h2E2);
        tick();
        wait_idle("mrst_idle", 30);
        repeat (5) read_word("mrst_order");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
